// File: rtl/reset_seq_pkg.sv
// Shared types and widths for the reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        S_POWERUP,
        S_WAIT_LOCK,
        S_DELAY,
        S_RUN
    } seq_state_t;

    localparam int unsigned LOSS_CNT_W  = 16;
    localparam int unsigned STAGE_IDX_W = 4;

endpackage

// File: rtl/lock_debounce.sv
// Per-stage lock conditioner: 2-flop synchroniser followed by a SYNC_LEN-deep
// all-ones filter, so a single low sample drops q_ok.
module lock_debounce #(
    parameter int unsigned SYNC_LEN = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic q_ok
);

    logic [1:0]          r_sync;
    logic [SYNC_LEN-1:0] r_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_shift <= '0;
        end else begin
            r_sync  <= {r_sync[0], d_async};
            r_shift <= (r_shift << 1) | SYNC_LEN'(r_sync[1]);
        end
    end

    assign q_ok = &r_shift;

endmodule

// File: rtl/reset_sequencer.sv
// N-stage reset/lock sequencer: releases per-domain resets in order once each
// lock is stable and its settle delay elapses. Optional watchdog: RSTSEQ_WATCHDOG_EN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES    = 4,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned POWERUP_DELAY = 125000000,
    parameter int unsigned SYNC_LEN      = 16,
    parameter int unsigned LOCK_TIMEOUT  = 1250000
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_STAGES-1:0]                lock_in,
    input  logic [NUM_STAGES-1:0][CNT_W-1:0]     stage_delay,
    input  logic                                 sw_reset,
    output logic [NUM_STAGES-1:0]                rst_out,
    output logic                                 all_ready,
    output logic [STAGE_IDX_W-1:0]               cur_stage,
    output logic [NUM_STAGES-1:0]                fault_sticky,
    output logic [LOSS_CNT_W-1:0]                loss_count,
    output logic                                 wd_timeout,
    output logic                                 wd_sticky
);

    seq_state_t             r_state, w_state_next;
    logic [CNT_W-1:0]       r_cnt, w_cnt_next;
    logic [STAGE_IDX_W-1:0] r_stage, w_stage_next;
    logic [NUM_STAGES-1:0]  r_rst_out, w_rst_next;
    logic                   r_all_ready;
    logic [NUM_STAGES-1:0]  r_fault, w_fault_next;
    logic [LOSS_CNT_W-1:0]  r_loss_cnt, w_loss_cnt_next;

    logic [NUM_STAGES-1:0]  w_lock_ok;
    logic [NUM_STAGES-1:0]  w_lost;
    logic [NUM_STAGES-1:0]  w_loss_mask;
    logic [NUM_STAGES-1:0]  w_stage_onehot;
    logic [STAGE_IDX_W-1:0] w_loss_idx;
    logic                   w_loss_any;
    logic                   w_lock_k;
    logic [CNT_W-1:0]       w_delay_k;
    logic                   w_wd_hit;
    logic                   w_wd_pulse;
    logic                   w_wd_sticky;

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_deb
        lock_debounce #(
            .SYNC_LEN(SYNC_LEN)
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .d_async(lock_in[g]),
            .q_ok   (w_lock_ok[g])
        );
    end

    // Select the current stage's lock/delay and locate the lowest released stage that lost lock
    always_comb begin
        w_lock_k       = 1'b0;
        w_delay_k      = '0;
        w_stage_onehot = '0;
        w_loss_idx     = '0;
        w_loss_mask    = '0;
        w_lost         = ~r_rst_out & ~w_lock_ok;
        w_loss_any     = (r_state != S_POWERUP) && (|w_lost);
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (r_stage == STAGE_IDX_W'(i)) begin
                w_lock_k          = w_lock_ok[i];
                w_delay_k         = stage_delay[i];
                w_stage_onehot[i] = 1'b1;
            end
            if (w_lost[NUM_STAGES-1-i]) begin
                w_loss_idx = STAGE_IDX_W'(NUM_STAGES-1-i);
            end
        end
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (STAGE_IDX_W'(i) >= w_loss_idx) begin
                w_loss_mask[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_POWERUP;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_stage_next    = r_stage;
        w_cnt_next      = r_cnt;
        w_rst_next      = r_rst_out;
        w_fault_next    = r_fault;
        w_loss_cnt_next = r_loss_cnt;

        case (r_state)
            S_POWERUP: begin
                if (r_cnt == CNT_W'(POWERUP_DELAY - 1)) begin
                    w_state_next = S_WAIT_LOCK;
                    w_stage_next = '0;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (w_lock_k) begin
                    w_state_next = S_DELAY;
                    w_cnt_next   = '0;
                end
            end
            S_DELAY: begin
                if (!w_lock_k) begin
                    w_state_next = S_WAIT_LOCK;
                end else if (r_cnt == w_delay_k) begin
                    w_rst_next = r_rst_out & ~w_stage_onehot;
                    w_cnt_next = '0;
                    if (r_stage == STAGE_IDX_W'(NUM_STAGES - 1)) begin
                        w_state_next = S_RUN;
                    end else begin
                        w_stage_next = r_stage + STAGE_IDX_W'(1);
                        w_state_next = S_WAIT_LOCK;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
            end
            default: begin
                w_state_next = S_POWERUP;
            end
        endcase

        if (w_wd_hit) begin
            w_rst_next = w_rst_next | w_stage_onehot;
        end

        // Priority: sw_reset > lock loss > normal sequencing
        if (w_loss_any) begin
            w_rst_next   = r_rst_out | w_loss_mask;
            w_stage_next = w_loss_idx;
            w_state_next = S_WAIT_LOCK;
            w_cnt_next   = '0;
            w_fault_next = r_fault | w_lost;
            if (r_loss_cnt != '1) begin
                w_loss_cnt_next = r_loss_cnt + LOSS_CNT_W'(1);
            end
        end

        if (sw_reset && (r_state != S_POWERUP)) begin
            w_rst_next      = '1;
            w_stage_next    = '0;
            w_state_next    = S_WAIT_LOCK;
            w_cnt_next      = '0;
            w_fault_next    = r_fault;
            w_loss_cnt_next = r_loss_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_stage     <= '0;
            r_rst_out   <= '1;
            r_all_ready <= 1'b0;
            r_fault     <= '0;
            r_loss_cnt  <= '0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_stage     <= w_stage_next;
            r_rst_out   <= w_rst_next;
            r_all_ready <= &(~w_rst_next);
            r_fault     <= w_fault_next;
            r_loss_cnt  <= w_loss_cnt_next;
        end
    end

`ifdef RSTSEQ_WATCHDOG_EN
    localparam int unsigned WD_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_wd_pulse;
    logic            r_wd_sticky;

    assign w_wd_hit = (r_state == S_WAIT_LOCK) && (r_wd_cnt == WD_W'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt    <= '0;
            r_wd_pulse  <= 1'b0;
            r_wd_sticky <= 1'b0;
        end else begin
            r_wd_pulse <= w_wd_hit;
            if (w_wd_hit) begin
                r_wd_sticky <= 1'b1;
            end
            if ((r_state != S_WAIT_LOCK) || w_wd_hit) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
            end
        end
    end

    assign w_wd_pulse  = r_wd_pulse;
    assign w_wd_sticky = r_wd_sticky;
`else
    logic w_unused_wd;

    assign w_wd_hit    = 1'b0;
    assign w_wd_pulse  = 1'b0;
    assign w_wd_sticky = 1'b0;
    assign w_unused_wd = (LOCK_TIMEOUT == 0);
`endif

    always_comb begin
        rst_out      = r_rst_out;
        all_ready    = r_all_ready;
        cur_stage    = r_stage;
        fault_sticky = r_fault;
        loss_count   = r_loss_cnt;
        wd_timeout   = w_wd_pulse;
        wd_sticky    = w_wd_sticky;
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: staged release, lock loss, sw_reset,
// mid-sequence rst and the lock-wait (watchdog) scenario.
module tb_reset_sequencer;

`ifdef RSTSEQ_WATCHDOG_EN
    localparam logic WD_EN = 1'b1;
`else
    localparam logic WD_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       lock_in;
    logic [3:0][15:0] stage_delay;
    logic             sw_reset;
    logic [3:0]       rst_out;
    logic             all_ready;
    logic [3:0]       cur_stage;
    logic [3:0]       fault_sticky;
    logic [15:0]      loss_count;
    logic             wd_timeout;
    logic             wd_sticky;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    reset_sequencer #(
        .NUM_STAGES   (4),
        .CNT_W        (16),
        .POWERUP_DELAY(20),
        .SYNC_LEN     (4),
        .LOCK_TIMEOUT (50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lock_in     (lock_in),
        .stage_delay (stage_delay),
        .sw_reset    (sw_reset),
        .rst_out     (rst_out),
        .all_ready   (all_ready),
        .cur_stage   (cur_stage),
        .fault_sticky(fault_sticky),
        .loss_count  (loss_count),
        .wd_timeout  (wd_timeout),
        .wd_sticky   (wd_sticky)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_rst_out"}, 32'(rst_out), 32'hF);
        check_eq({tag, "_all_ready"}, 32'(all_ready), 32'h0);
        check_eq({tag, "_cur_stage"}, 32'(cur_stage), 32'h0);
        check_eq({tag, "_fault"}, 32'(fault_sticky), 32'h0);
        check_eq({tag, "_loss"}, 32'(loss_count), 32'h0);
        check_eq({tag, "_wd_pulse"}, 32'(wd_timeout), 32'h0);
        check_eq({tag, "_wd_sticky"}, 32'(wd_sticky), 32'h0);
    endtask

    // Counted from the first edge with rst low: power-up ends at edge 20,
    // lock_ok up at edge 6, so stage 0 drops at 20+2+5=27, then 32, 34, 38.
    task automatic powerup_seq(input string tag);
        wait_to(26); check_eq({tag, "_s0_before"}, 32'(rst_out), 32'hF);
        wait_to(27); check_eq({tag, "_s0_rel"}, 32'(rst_out), 32'hE);
                     check_eq({tag, "_k1"}, 32'(cur_stage), 32'h1);
        wait_to(31); check_eq({tag, "_s1_before"}, 32'(rst_out), 32'hE);
        wait_to(32); check_eq({tag, "_s1_rel"}, 32'(rst_out), 32'hC);
        wait_to(34); check_eq({tag, "_s2_rel"}, 32'(rst_out), 32'h8);
        wait_to(37); check_eq({tag, "_s3_before"}, 32'(rst_out), 32'h8);
                     check_eq({tag, "_rdy_before"}, 32'(all_ready), 32'h0);
        wait_to(38); check_eq({tag, "_s3_rel"}, 32'(rst_out), 32'h0);
                     check_eq({tag, "_rdy"}, 32'(all_ready), 32'h1);
                     check_eq({tag, "_k3"}, 32'(cur_stage), 32'h3);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        lock_in     = 4'hF;
        sw_reset    = 1'b0;
        stage_delay = {16'd2, 16'd0, 16'd3, 16'd5};

        tick(); tick();
        check_reset_vals("init");
        rst = 1'b0;
        cyc = 0;
        powerup_seq("pu1");

        // Single-cycle drop of lock_in[2] while running
        tick(); tick();
        cyc = 0;
        lock_in[2] = 1'b0;
        wait_to(1);  lock_in[2] = 1'b1;
        wait_to(3);  check_eq("loss2_before", 32'(rst_out), 32'h0);
        wait_to(4);  check_eq("loss2_rst", 32'(rst_out), 32'hC);
                     check_eq("loss2_fault", 32'(fault_sticky), 32'h4);
                     check_eq("loss2_cnt", 32'(loss_count), 32'h1);
                     check_eq("loss2_k", 32'(cur_stage), 32'h2);
                     check_eq("loss2_rdy", 32'(all_ready), 32'h0);
        wait_to(8);  check_eq("loss2_s2_before", 32'(rst_out), 32'hC);
        wait_to(9);  check_eq("loss2_s2_rel", 32'(rst_out), 32'h8);
        wait_to(12); check_eq("loss2_s3_before", 32'(rst_out), 32'h8);
        wait_to(13); check_eq("loss2_s3_rel", 32'(rst_out), 32'h0);
                     check_eq("loss2_rdy_back", 32'(all_ready), 32'h1);

        // sw_reset from S_RUN: no power-up, counters untouched
        tick(); tick();
        cyc = 0;
        sw_reset = 1'b1;
        wait_to(1);  sw_reset = 1'b0;
                     check_eq("sw_rst", 32'(rst_out), 32'hF);
                     check_eq("sw_k", 32'(cur_stage), 32'h0);
                     check_eq("sw_cnt", 32'(loss_count), 32'h1);
                     check_eq("sw_fault", 32'(fault_sticky), 32'h4);
        wait_to(7);  check_eq("sw_s0_before", 32'(rst_out), 32'hF);
        wait_to(8);  check_eq("sw_s0_rel", 32'(rst_out), 32'hE);
        wait_to(13); check_eq("sw_s1_rel", 32'(rst_out), 32'hC);
        wait_to(14); check_eq("sw_in_s2_delay", 32'(rst_out), 32'hC);

        // rst while stage 2 is in its settle phase
        rst = 1'b1;
        tick();
        check_reset_vals("mid_rst");
        tick();
        rst = 1'b0;
        cyc = 0;
        powerup_seq("pu2");

        // Simultaneous loss on stages 1 and 3 counts once, lowest stage wins
        tick(); tick();
        cyc = 0;
        lock_in[1] = 1'b0;
        lock_in[3] = 1'b0;
        wait_to(1);  lock_in = 4'hF;
        wait_to(4);  check_eq("loss13_rst", 32'(rst_out), 32'hE);
                     check_eq("loss13_k", 32'(cur_stage), 32'h1);
                     check_eq("loss13_fault", 32'(fault_sticky), 32'hA);
                     check_eq("loss13_cnt", 32'(loss_count), 32'h1);
        wait_to(11); check_eq("loss13_s1_before", 32'(rst_out), 32'hE);
        wait_to(12); check_eq("loss13_s1_rel", 32'(rst_out), 32'hC);
        wait_to(14); check_eq("loss13_s2_rel", 32'(rst_out), 32'h8);
        wait_to(18); check_eq("loss13_s3_rel", 32'(rst_out), 32'h0);

        // Stage 0 lock absent after power-up: watchdog retries while waiting
        tick(); tick();
        rst = 1'b1;
        lock_in[0] = 1'b0;
        tick(); tick();
        rst = 1'b0;
        cyc = 0;
        wait_to(20);  check_eq("wd_wait_rst", 32'(rst_out), 32'hF);
        wait_to(69);  check_eq("wd_pre_pulse", 32'(wd_timeout), 32'h0);
                      check_eq("wd_pre_sticky", 32'(wd_sticky), 32'h0);
        wait_to(70);  check_eq("wd_pulse1", 32'(wd_timeout), 32'(WD_EN));
        wait_to(71);  check_eq("wd_pulse1_end", 32'(wd_timeout), 32'h0);
                      check_eq("wd_sticky", 32'(wd_sticky), 32'(WD_EN));
                      check_eq("wd_still_rst", 32'(rst_out), 32'hF);
        wait_to(119); check_eq("wd_pre_pulse2", 32'(wd_timeout), 32'h0);
        wait_to(120); check_eq("wd_pulse2", 32'(wd_timeout), 32'(WD_EN));
        lock_in[0] = 1'b1;
        wait_to(132); check_eq("wd_s0_before", 32'(rst_out), 32'hF);
        wait_to(133); check_eq("wd_s0_rel", 32'(rst_out), 32'hE);
                      check_eq("wd_loss_none", 32'(loss_count), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
